fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 121 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Turns a synchronous FIFO read port (latency 0..2) into a valid/ready stream through a 4-entry skid buffer.
// Optional beat/stall statistics are compiled in with `define FIFO_RD_STREAM_STAT_EN.
module fifo_rd_stream #(
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    output logic          o_fifo_rd_en,
    input  logic [DW-1:0] i_fifo_dout,
    input  logic          i_fifo_empty,
    output logic          o_tvalid,
    output logic [DW-1:0] o_tdata,
    input  logic          i_tready
`ifdef FIFO_RD_STREAM_STAT_EN
    ,
    output logic [31:0]   o_beat_cnt,
    output logic [31:0]   o_stall_cnt
`endif
);

    logic [DW-1:0] mem [4];
    logic [1:0]    wptr;
    logic [1:0]    rptr;
    logic [2:0]    occ;
    logic [1:0]    infl;
    logic [3:0]    credit;
    logic          ret_valid;
    logic          push;
    logic          pop;

    // Reads already issued count against the buffer, so a return always has a free slot.
    always_comb begin
        credit = {1'b0, occ} + {2'b00, infl};
    end

    assign o_fifo_rd_en = !rst && !i_fifo_empty && !i_clr && (credit < 4'd4);
    assign push         = ret_valid && !i_clr;
    assign o_tvalid     = (occ != 3'd0);
    assign pop          = o_tvalid && i_tready && !i_clr;
    assign o_tdata      = mem[rptr];

    generate
        if (RD_LATENCY == 0) begin : g_fwft
            assign ret_valid = o_fifo_rd_en;
            assign infl      = 2'd0;
        end else begin : g_pipe
            logic [RD_LATENCY-1:0] vld;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld  <= '0;
                    infl <= 2'd0;
                end else if (i_clr) begin
                    vld  <= '0;
                    infl <= 2'd0;
                end else begin
                    vld[0] <= o_fifo_rd_en;
                    for (int k = 1; k < RD_LATENCY; k++) begin
                        vld[k] <= vld[k-1];
                    end
                    infl <= infl + {1'b0, o_fifo_rd_en} - {1'b0, vld[RD_LATENCY-1]};
                end
            end

            assign ret_valid = vld[RD_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= 2'd0;
            rptr <= 2'd0;
            occ  <= 3'd0;
        end else if (i_clr) begin
            wptr <= 2'd0;
            rptr <= 2'd0;
            occ  <= 3'd0;
        end else begin
            if (push) begin
                wptr <= wptr + 2'd1;
            end
            if (pop) begin
                rptr <= rptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Payload storage carries no reset; occ alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= i_fifo_dout;
        end
    end

`ifdef FIFO_RD_STREAM_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_beat_cnt  <= 32'd0;
            o_stall_cnt <= 32'd0;
        end else if (i_clr) begin
            o_beat_cnt  <= 32'd0;
            o_stall_cnt <= 32'd0;
        end else begin
            if (o_tvalid && i_tready) begin
                o_beat_cnt <= o_beat_cnt + 32'd1;
            end
            if (o_tvalid && !i_tready) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: one instance per read latency (0, 1, 2), all fed from one shared word stream.
// Each instance has its own FIFO read-port model and an expected-beat queue.
module tb_fifo_rd_stream;

    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        tready;
    logic [31:0] src_mem [128];
    int          src_cnt;
    int          n_checks;
    int          n_errors;
    int          chk_point;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int count, input logic [31:0] first);
        for (int i = 0; i < count; i++) begin
            src_mem[src_cnt + i] = first + i;
        end
        src_cnt = src_cnt + count;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lat
        logic        rd_en;
        logic        empty;
        logic        tvalid;
        logic [31:0] tdata;
        logic [31:0] dout;
        logic [31:0] exp_q [$];
        logic [31:0] held;
        logic        stall_prev = 1'b0;
        int          rd_idx     = 0;
        int          seen       = 0;
        int          rd_pulses  = 0;
        int          rd_base    = 0;
        int          cyc        = 0;
        int          lat_state  = 0;
        int          rd_cyc     = 0;
        int          gap_left   = 0;
        int          beats_m    = 0;
        int          stalls_m   = 0;
`ifdef FIFO_RD_STREAM_STAT_EN
        logic [31:0] beat_cnt;
        logic [31:0] stall_cnt;
`endif

        assign empty = (rd_idx >= src_cnt);

        fifo_rd_stream #(.DW(DW), .RD_LATENCY(g)) dut (
            .clk          (clk),
            .rst          (rst),
            .i_clr        (clr),
            .o_fifo_rd_en (rd_en),
            .i_fifo_dout  (dout),
            .i_fifo_empty (empty),
            .o_tvalid     (tvalid),
            .o_tdata      (tdata),
            .i_tready     (tready)
`ifdef FIFO_RD_STREAM_STAT_EN
            ,
            .o_beat_cnt   (beat_cnt),
            .o_stall_cnt  (stall_cnt)
`endif
        );

        // FIFO read port: first-word-fall-through for latency 0, registered stages otherwise.
        if (g == 0) begin : g_fwft
            assign dout = (rd_idx < src_cnt) ? src_mem[rd_idx[6:0]] : 32'hDEAD_BEEF;
            always @(posedge clk) begin
                if (rd_en) rd_idx <= rd_idx + 1;
            end
        end else begin : g_sync
            logic [31:0] pipe [2];
            always @(posedge clk) begin
                if (rd_en) begin
                    rd_idx  <= rd_idx + 1;
                    pipe[0] <= src_mem[rd_idx[6:0]];
                end else begin
                    pipe[0] <= 32'hDEAD_BEEF;
                end
                pipe[1] <= pipe[0];
            end
            assign dout = pipe[g-1];
        end

        // After a flush or reset, only words still unread in the FIFO may ever appear.
        always @(negedge clk) begin
            cyc++;
            while (seen < src_cnt) begin
                exp_q.push_back(src_mem[seen[6:0]]);
                seen++;
            end

`ifdef FIFO_RD_STREAM_STAT_EN
            if (chk_point != 0) begin
                checkOutput($sformatf("L%0d_beat_cnt", g), beat_cnt, beats_m);
                checkOutput($sformatf("L%0d_stall_cnt", g), stall_cnt, stalls_m);
            end
`endif
            case (chk_point)
                10: lat_state = 1;
                20: rd_base = rd_pulses;
                21: begin
                    checkOutput($sformatf("L%0d_stall_reads", g), rd_pulses - rd_base, 4);
                    checkOutput($sformatf("L%0d_stall_tvalid", g), tvalid, 1'b1);
                    checkOutput($sformatf("L%0d_stall_first", g), tdata, 32'h21);
                end
                30: begin
                    checkOutput($sformatf("L%0d_drained", g), exp_q.size(), 0);
                    checkOutput($sformatf("L%0d_idle_tvalid", g), tvalid, 1'b0);
                end
                40: checkOutput($sformatf("L%0d_clr_tvalid", g), tvalid, 1'b0);
                99: checkOutput($sformatf("L%0d_latency_seen", g), lat_state, 3);
                default: ;
            endcase

            if (rst) begin
                checkOutput($sformatf("L%0d_rst_tvalid", g), tvalid, 1'b0);
                checkOutput($sformatf("L%0d_rst_rd_en", g), rd_en, 1'b0);
                exp_q.delete();
                for (int i = rd_idx; i < src_cnt; i++) exp_q.push_back(src_mem[i[6:0]]);
                seen       = src_cnt;
                stall_prev = 1'b0;
                beats_m    = 0;
                stalls_m   = 0;
            end else begin
                if (stall_prev) begin
                    checkOutput($sformatf("L%0d_hold_tvalid", g), tvalid, 1'b1);
                    checkOutput($sformatf("L%0d_hold_tdata", g), tdata, held);
                end
                if (clr) begin
                    exp_q.delete();
                    for (int i = rd_idx; i < src_cnt; i++) exp_q.push_back(src_mem[i[6:0]]);
                    seen       = src_cnt;
                    stall_prev = 1'b0;
                    beats_m    = 0;
                    stalls_m   = 0;
                end else begin
                    if (tvalid && tready) begin
                        if (exp_q.size() == 0) checkOutput($sformatf("L%0d_beat_expected", g), 0, 1);
                        else checkOutput($sformatf("L%0d_beat", g), tdata, exp_q.pop_front());
                        beats_m++;
                    end
                    if (tvalid && !tready) stalls_m++;
                    stall_prev = tvalid && !tready;
                    held       = tdata;
                end

                if (lat_state == 1 && rd_en) begin
                    rd_cyc    = cyc;
                    lat_state = 2;
                end else if (lat_state == 2 && tvalid) begin
                    checkOutput($sformatf("L%0d_latency", g), cyc - rd_cyc, g + 1);
                    lat_state = 3;
                    gap_left  = 7;
                end else if (lat_state == 3 && gap_left > 0) begin
                    checkOutput($sformatf("L%0d_no_gap", g), tvalid, 1'b1);
                    gap_left--;
                end
                if (rd_en) rd_pulses++;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        tready    = 1'b0;
        src_cnt   = 0;
        n_checks  = 0;
        n_errors  = 0;
        chk_point = 0;
        tick(3);
        rst = 1'b0;

        // Burst of eight with the sink always ready: latency and gap-free streaming.
        tready = 1'b1;
        tick(2);
        chk_point = 10;
        applyStimulus(8, 32'h11);
        tick(1);
        chk_point = 0;
        tick(20);
        chk_point = 30;
        tick(1);
        chk_point = 0;

        // Ten words against a stalled sink: credit limit, then release.
        tready = 1'b0;
        tick(1);
        chk_point = 20;
        applyStimulus(10, 32'h21);
        tick(1);
        chk_point = 0;
        tick(11);
        chk_point = 21;
        tick(1);
        chk_point = 0;
        tready = 1'b1;
        tick(25);
        chk_point = 30;
        tick(1);
        chk_point = 0;

        // Sink toggling every cycle.
        tready = 1'b0;
        applyStimulus(6, 32'h31);
        for (int i = 0; i < 24; i++) begin
            tick(1);
            tready = ~tready;
        end
        tready = 1'b1;
        tick(10);
        chk_point = 30;
        tick(1);
        chk_point = 0;

        // Flush with a partly full buffer and a read in flight.
        tready = 1'b0;
        applyStimulus(10, 32'h41);
        tick(10);
        tready = 1'b1;
        tick(1);
        tready = 1'b0;
        tick(1);
        clr = 1'b1;
        tick(1);
        clr       = 1'b0;
        chk_point = 40;
        tick(1);
        chk_point = 0;
        tready = 1'b1;
        tick(20);
        chk_point = 30;
        tick(1);
        chk_point = 0;

        // Asynchronous reset pulse in the middle of a burst.
        applyStimulus(10, 32'h51);
        tick(3);
        #1 rst = 1'b1;
        #1;
        checkOutput("L0_async_tvalid", g_lat[0].tvalid, 1'b0);
        checkOutput("L0_async_rd_en", g_lat[0].rd_en, 1'b0);
        checkOutput("L1_async_tvalid", g_lat[1].tvalid, 1'b0);
        checkOutput("L1_async_rd_en", g_lat[1].rd_en, 1'b0);
        checkOutput("L2_async_tvalid", g_lat[2].tvalid, 1'b0);
        checkOutput("L2_async_rd_en", g_lat[2].rd_en, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("L0_release_rd_en", g_lat[0].rd_en, 1'b1);
        checkOutput("L1_release_rd_en", g_lat[1].rd_en, 1'b1);
        checkOutput("L2_release_rd_en", g_lat[2].rd_en, 1'b1);
        checkOutput("L0_release_tvalid", g_lat[0].tvalid, 1'b0);
        checkOutput("L1_release_tvalid", g_lat[1].tvalid, 1'b0);
        checkOutput("L2_release_tvalid", g_lat[2].tvalid, 1'b0);
        tick(1);
        chk_point = 51;
        tick(1);
        chk_point = 0;
        tick(20);
        chk_point = 30;
        tick(1);
        chk_point = 99;
        tick(1);
        chk_point = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
